mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 wd_i / wreg_i / wdata_i  input  5/1/32  destination register, write enable and ALU result from the EX/MEM register.
REQ-004 whilo_i / hi_i / lo_i  input  1/32/32  HI/LO write enable and values.
REQ-005 aluop_i / mem_addr_i / reg2_i  input  8/32/32  operation code, effective address and store data.
REQ-006 flush_i  input  1  squashes the current instruction and any link.
REQ-007 wd_o / wreg_o / wdata_o / whilo_o / hi_o / lo_o  output  5/1/32/1/32/32  results to the MEM/WB register.
REQ-008 bus_addr_o / bus_data_o / bus_sel_o / bus_we_o / bus_stb_o  output  32/32/4/1/1  data-bus master request; bus_addr_o is word aligned.
REQ-009 bus_data_i / bus_ack_i  input  32/1  bus read data and one-cycle completion strobe.
REQ-010 stallreq_o  output  1  requests a pipeline stall at stage index 4.
REQ-011 misalign_o  output  1  one-cycle pulse when the access is misaligned.

Function
REQ-012 Non-memory aluop: wd/wreg/wdata/whilo/hi/lo pass through combinationally, stallreq_o=0, bus_stb_o=0.
REQ-013 Memory ops: LB, LBU, LH, LHU, LW, LL, SB, SH, SW, SC.
REQ-014 FSM states: IDLE, BUSY, DONE.
- IDLE->BUSY when a memory op is present, flush_i=0, and the access is aligned.
- BUSY->DONE on bus_ack_i=1.
- DONE->IDLE unconditionally.
REQ-015 stallreq_o=1 in IDLE while a qualifying memory op is present, and throughout BUSY; stallreq_o=0 in DONE.
REQ-016 bus_stb_o=1 only in BUSY; address, data, sel and we stay stable until ack.
REQ-017 Byte lanes are big-endian: addr[1:0]=00 selects sel 1000 / data[31:24]; 11 selects sel 0001 / data[7:0].
REQ-018 Halfword lanes: addr[1]=0 selects sel 1100; addr[1]=1 selects sel 0011.
REQ-019 Word accesses use sel 1111.
REQ-020 Stores replicate the byte or halfword of reg2_i across all lanes; bus_we_o=1.
REQ-021 Read data is captured into an internal register on ack.
REQ-022 In DONE, wdata_o is the selected lane of the captured read data: sign-extended for LB/LH, zero-extended for LBU/LHU, unmodified for LW/LL.
REQ-023 For stores, wreg_o is forced to 0 in every state.
REQ-024 For loads, wreg_o = wreg_i only in DONE; wreg_o=0 in IDLE and BUSY.
REQ-025 A halfword access with addr[0]=1, or a word access with addr[1:0]!=00, gets no bus cycle: wreg_o=0, misalign_o=1, stallreq_o=0, FSM stays IDLE.
REQ-026 llbit register: set to 1 when LL reaches DONE; cleared by SC reaching DONE, by flush_i, or by reset.
REQ-027 SC with llbit=0: no bus cycle, wdata_o=0, wreg_o=wreg_i, stallreq_o=0.
REQ-028 SC with llbit=1: performs an SW; in DONE, wdata_o=1 and wreg_o=wreg_i.
REQ-029 flush_i=1 in BUSY: the outstanding request is held until ack, then the FSM goes directly to IDLE with no register write and no llbit change; stallreq_o=0 from the flush cycle onward.
REQ-030 The latency of an aligned access is 2 + N cycles, where N is the number of BUSY cycles before ack.

Reset
REQ-031 On rst: FSM=IDLE, llbit=0, captured data=0.
REQ-032 During rst: bus_stb_o=0, bus_we_o=0, bus_sel_o=0, stallreq_o=0, misalign_o=0, wreg_o=0, whilo_o=0; all data outputs 0.
REQ-033 rst asserted mid-access abandons the transaction immediately; a late ack is ignored.

Structure
REQ-034 Aluop codes, register-address widths, Stop/NoStop and ZeroWord constants come from the shared defines file.
REQ-035 Lane select, sign/zero extension and read formatting form the sub-module mem_lane_fmt (combinational); the FSM and llbit stay in mem_stage.

Verification
REQ-036 LB at addr 0x103, bus_data_i=0x000000F0, ack after 1 BUSY cycle -> sel 0001, stallreq high for 2 cycles, wdata_o=0xFFFFFFF0, wreg_o=1.
REQ-037 SH at addr 0x202, reg2_i=0x1234ABCD -> bus_data_o=0xABCDABCD, sel 0011, we=1, wreg_o=0.
REQ-038 LW at addr 0x001 -> misalign_o=1, no bus_stb_o, stallreq_o=0.
REQ-039 SC with no preceding LL -> no bus cycle, wdata_o=0; LL 0x40 then SC 0x40 -> one write, wdata_o=1, llbit=0 afterwards.
REQ-040 flush_i during BUSY with ack delayed 3 cycles -> stb held until ack, no write-back, llbit unchanged.
REQ-041 rst during BUSY -> next cycle bus_stb_o=0, FSM IDLE; a following ack has no effect.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: widths, stall codes,
// memory aluop encodings and small opcode classifiers.
package mem_stage_pkg;

    localparam int RegAddrBus = 5;
    localparam int RegBus     = 32;
    localparam int AluOpBus   = 8;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [AluOpBus-1:0] EXE_LL_OP  = 8'b1111_0000;
    localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [AluOpBus-1:0] EXE_SC_OP  = 8'b1111_1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_e;

    // SZ_NONE doubles as "not a memory operation".
    function automatic mem_size_e op_size(input logic [AluOpBus-1:0] op);
        mem_size_e sz;
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP:            sz = SZ_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:            sz = SZ_HALF;
            EXE_LW_OP, EXE_LL_OP, EXE_SW_OP, EXE_SC_OP:  sz = SZ_WORD;
            default:                                     sz = SZ_NONE;
        endcase
        return sz;
    endfunction

    function automatic logic op_is_store(input logic [AluOpBus-1:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) ||
               (op == EXE_SW_OP) || (op == EXE_SC_OP);
    endfunction

    function automatic logic op_is_signed(input logic [AluOpBus-1:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LH_OP);
    endfunction

endpackage

// File: rtl/mem_stage_lane_fmt.sv
// Combinational byte-lane logic: big-endian select/replication for requests
// and lane extraction with sign/zero extension for returned read data.
module mem_lane_fmt
    import mem_stage_pkg::*;
(
    input  logic [AluOpBus-1:0] req_op_i,
    input  logic [1:0]          req_off_i,
    input  logic [RegBus-1:0]   req_src_i,
    output logic [3:0]          req_sel_o,
    output logic [RegBus-1:0]   req_data_o,
    output logic                req_misalign_o,
    input  logic [AluOpBus-1:0] rsp_op_i,
    input  logic [1:0]          rsp_off_i,
    input  logic [RegBus-1:0]   rsp_raw_i,
    output logic [RegBus-1:0]   rsp_data_o
);

    logic [7:0]  rsp_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rsp_byte[gi] = rsp_raw_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        req_sel_o      = 4'b0000;
        req_data_o     = req_src_i;
        req_misalign_o = 1'b0;
        case (op_size(req_op_i))
            SZ_BYTE: begin
                req_sel_o  = 4'b1000 >> req_off_i;
                req_data_o = {4{req_src_i[7:0]}};
            end
            SZ_HALF: begin
                req_sel_o      = req_off_i[1] ? 4'b0011 : 4'b1100;
                req_data_o     = {2{req_src_i[15:0]}};
                req_misalign_o = req_off_i[0];
            end
            SZ_WORD: begin
                req_sel_o      = 4'b1111;
                req_misalign_o = |req_off_i;
            end
            default: req_sel_o = 4'b0000;
        endcase
    end

    // Offset 00 is the most significant byte, hence the inverted lane index.
    always_comb begin
        sel_byte   = rsp_byte[~rsp_off_i];
        sel_half   = rsp_off_i[1] ? rsp_raw_i[15:0] : rsp_raw_i[31:16];
        rsp_data_o = rsp_raw_i;
        case (op_size(rsp_op_i))
            SZ_BYTE: rsp_data_o = {{24{op_is_signed(rsp_op_i) & sel_byte[7]}}, sel_byte};
            SZ_HALF: rsp_data_o = {{16{op_is_signed(rsp_op_i) & sel_half[15]}}, sel_half};
            default: rsp_data_o = rsp_raw_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: bus master FSM with stall requests,
// misalignment detection and LL/SC link tracking.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddrBus-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [RegBus-1:0]     wdata_i,
    input  logic                  whilo_i,
    input  logic [RegBus-1:0]     hi_i,
    input  logic [RegBus-1:0]     lo_i,
    input  logic [AluOpBus-1:0]   aluop_i,
    input  logic [RegBus-1:0]     mem_addr_i,
    input  logic [RegBus-1:0]     reg2_i,
    input  logic                  flush_i,
    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [RegBus-1:0]     wdata_o,
    output logic                  whilo_o,
    output logic [RegBus-1:0]     hi_o,
    output logic [RegBus-1:0]     lo_o,
    output logic [RegBus-1:0]     bus_addr_o,
    output logic [RegBus-1:0]     bus_data_o,
    output logic [3:0]            bus_sel_o,
    output logic                  bus_we_o,
    output logic                  bus_stb_o,
    input  logic [RegBus-1:0]     bus_data_i,
    input  logic                  bus_ack_i,
    output logic                  stallreq_o,
    output logic                  misalign_o
);

    mem_state_e          state_q, state_d;
    logic                llbit_q, llbit_d;
    logic                flushed_q, flushed_d;
    logic [RegBus-1:0]   rdata_q, rdata_d;
    logic [RegBus-1:0]   req_addr_q, req_addr_d;
    logic [RegBus-1:0]   req_data_q, req_data_d;
    logic [3:0]          req_sel_q, req_sel_d;
    logic                req_we_q, req_we_d;
    logic [AluOpBus-1:0] req_op_q, req_op_d;
    logic [1:0]          req_off_q, req_off_d;

    logic [3:0]          lane_sel;
    logic [RegBus-1:0]   lane_wdata;
    logic                lane_misalign;
    logic [RegBus-1:0]   fmt_rdata;
    logic                mem_op;
    logic                sc_fail;
    logic                busy_squashed;

    mem_lane_fmt u_lane_fmt (
        .req_op_i       (aluop_i),
        .req_off_i      (mem_addr_i[1:0]),
        .req_src_i      (reg2_i),
        .req_sel_o      (lane_sel),
        .req_data_o     (lane_wdata),
        .req_misalign_o (lane_misalign),
        .rsp_op_i       (req_op_q),
        .rsp_off_i      (req_off_q),
        .rsp_raw_i      (rdata_q),
        .rsp_data_o     (fmt_rdata)
    );

    assign mem_op        = (op_size(aluop_i) != SZ_NONE);
    assign sc_fail       = (aluop_i == EXE_SC_OP) && !llbit_q;
    assign busy_squashed = flushed_q || flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            llbit_q    <= 1'b0;
            flushed_q  <= 1'b0;
            rdata_q    <= ZeroWord;
            req_addr_q <= ZeroWord;
            req_data_q <= ZeroWord;
            req_sel_q  <= 4'b0000;
            req_we_q   <= 1'b0;
            req_op_q   <= '0;
            req_off_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            llbit_q    <= llbit_d;
            flushed_q  <= flushed_d;
            rdata_q    <= rdata_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            req_sel_q  <= req_sel_d;
            req_we_q   <= req_we_d;
            req_op_q   <= req_op_d;
            req_off_q  <= req_off_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        llbit_d    = llbit_q;
        flushed_d  = flushed_q;
        rdata_d    = rdata_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        req_sel_d  = req_sel_q;
        req_we_d   = req_we_q;
        req_op_d   = req_op_q;
        req_off_d  = req_off_q;

        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        whilo_o    = whilo_i;
        hi_o       = hi_i;
        lo_o       = lo_i;
        bus_addr_o = ZeroWord;
        bus_data_o = ZeroWord;
        bus_sel_o  = 4'b0000;
        bus_we_o   = 1'b0;
        bus_stb_o  = 1'b0;
        stallreq_o = NoStop;
        misalign_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (flush_i) llbit_d = 1'b0;
                if (mem_op) begin
                    wreg_o = 1'b0;
                    if (!flush_i) begin
                        if (lane_misalign) begin
                            misalign_o = 1'b1;
                        end else if (sc_fail) begin
                            wdata_o = ZeroWord;
                            wreg_o  = wreg_i;
                        end else begin
                            stallreq_o = Stop;
                            state_d    = ST_BUSY;
                            req_addr_d = {mem_addr_i[RegBus-1:2], 2'b00};
                            req_data_d = lane_wdata;
                            req_sel_d  = lane_sel;
                            req_we_d   = op_is_store(aluop_i);
                            req_op_d   = aluop_i;
                            req_off_d  = mem_addr_i[1:0];
                        end
                    end
                end
            end
            ST_BUSY: begin
                bus_addr_o = req_addr_q;
                bus_data_o = req_data_q;
                bus_sel_o  = req_sel_q;
                bus_we_o   = req_we_q;
                bus_stb_o  = 1'b1;
                if (mem_op) wreg_o = 1'b0;
                if (!busy_squashed) stallreq_o = Stop;
                if (flush_i) flushed_d = 1'b1;
                // A flushed access still runs to its ack so the bus sees a clean handshake.
                if (bus_ack_i) begin
                    rdata_d   = bus_data_i;
                    flushed_d = 1'b0;
                    if (busy_squashed) state_d = ST_IDLE;
                    else               state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (flush_i) begin
                    wreg_o  = 1'b0;
                    llbit_d = 1'b0;
                end else if (op_is_store(req_op_q)) begin
                    wreg_o = 1'b0;
                    if (req_op_q == EXE_SC_OP) begin
                        wdata_o = {{(RegBus-1){1'b0}}, 1'b1};
                        wreg_o  = wreg_i;
                        llbit_d = 1'b0;
                    end
                end else begin
                    wdata_o = fmt_rdata;
                    wreg_o  = wreg_i;
                    if (req_op_q == EXE_LL_OP) llbit_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            wd_o       = '0;
            wreg_o     = 1'b0;
            wdata_o    = ZeroWord;
            whilo_o    = 1'b0;
            hi_o       = ZeroWord;
            lo_o       = ZeroWord;
            bus_addr_o = ZeroWord;
            bus_data_o = ZeroWord;
            bus_sel_o  = 4'b0000;
            bus_we_o   = 1'b0;
            bus_stb_o  = 1'b0;
            stallreq_o = NoStop;
            misalign_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level model of each
// instruction, per-cycle compare process, directed and random stimulus.
module tb_mem_stage;

    localparam logic [7:0] OP_LB  = 8'hE0, OP_LBU = 8'hE4, OP_LH = 8'hE1, OP_LHU = 8'hE5;
    localparam logic [7:0] OP_LW  = 8'hE3, OP_LL  = 8'hF0, OP_SB = 8'hE8, OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB, OP_SC  = 8'hF8, OP_NOP = 8'h00;

    logic        clk, rst;
    logic [4:0]  wd_i, wd_o;
    logic        wreg_i, wreg_o, whilo_i, whilo_o, flush_i;
    logic [31:0] wdata_i, wdata_o, hi_i, hi_o, lo_i, lo_o;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i, bus_addr_o, bus_data_o, bus_data_i;
    logic [3:0]  bus_sel_o;
    logic        bus_we_o, bus_stb_o, bus_ack_i, stallreq_o, misalign_o;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .flush_i(flush_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_sel_o(bus_sel_o),
        .bus_we_o(bus_we_o), .bus_stb_o(bus_stb_o),
        .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i),
        .stallreq_o(stallreq_o), .misalign_o(misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs for the current cycle, set by the driver.
    logic        chk_en = 1'b0;
    logic        e_stall, e_stb, e_mis, e_wreg, e_whilo, e_we;
    logic [4:0]  e_wd;
    logic [3:0]  e_sel;
    logic [31:0] e_wdata, e_hi, e_lo, e_addr, e_bdata;
    logic        chk_wdata, chk_bus, chk_bdata;

    // Observations used by literal checks.
    int          stall_seen, writes_seen, stb_seen;
    logic [31:0] last_wdata, last_bdata;
    logic [3:0]  last_sel;
    logic        last_wreg, last_we, last_mis;

    logic        model_llbit;
    logic        wreg_force;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (stallreq_o === 1'b1) stall_seen++;
            if (bus_stb_o === 1'b1) begin
                stb_seen++;
                last_sel   = bus_sel_o;
                last_bdata = bus_data_o;
                last_we    = bus_we_o;
                if (bus_we_o && bus_ack_i) writes_seen++;
            end
            if (chk_wdata) last_wdata = wdata_o;
            last_wreg = wreg_o;
            last_mis  = misalign_o;
            chk("stallreq", {31'd0, stallreq_o}, {31'd0, e_stall});
            chk("bus_stb", {31'd0, bus_stb_o}, {31'd0, e_stb});
            chk("misalign", {31'd0, misalign_o}, {31'd0, e_mis});
            chk("wreg", {31'd0, wreg_o}, {31'd0, e_wreg});
            chk("wd", {27'd0, wd_o}, {27'd0, e_wd});
            chk("whilo", {31'd0, whilo_o}, {31'd0, e_whilo});
            chk("hi", hi_o, e_hi);
            chk("lo", lo_o, e_lo);
            if (chk_wdata) chk("wdata", wdata_o, e_wdata);
            if (chk_bus) begin
                chk("bus_addr", bus_addr_o, e_addr);
                chk("bus_sel", {28'd0, bus_sel_o}, {28'd0, e_sel});
                chk("bus_we", {31'd0, bus_we_o}, {31'd0, e_we});
            end
            if (chk_bdata) chk("bus_data", bus_data_o, e_bdata);
        end
    end

    function automatic int m_size(input logic [7:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        if (op == OP_LW || op == OP_LL || op == OP_SW || op == OP_SC) return 4;
        return 0;
    endfunction

    function automatic logic m_store(input logic [7:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW || op == OP_SC;
    endfunction

    function automatic logic [3:0] m_sel(input int sz, input logic [1:0] off);
        if (sz == 4) return 4'hF;
        if (sz == 2) return (off == 2'd0) ? 4'hC : 4'h3;
        return 4'(8 >> off);
    endfunction

    function automatic logic [31:0] m_wbus(input int sz, input logic [31:0] v);
        if (sz == 1) return (v & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (v & 32'hFFFF) * 32'h0001_0001;
        return v;
    endfunction

    // Big-endian lane: the addressed bytes sit (4 - size - offset) bytes above bit 0.
    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [1:0] off, input logic [31:0] d);
        int sz, sh;
        logic [63:0] mask, v;
        sz = m_size(op);
        if (sz == 4) return d;
        sh   = 8 * (4 - sz - int'(off));
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v    = ({32'd0, d} >> sh) & mask;
        if ((op == OP_LB || op == OP_LH) && v[8*sz-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic rand_inputs(input logic [7:0] op);
        aluop_i = op;
        wd_i    = 5'($urandom);
        wreg_i  = wreg_force ? 1'b1 : 1'($urandom);
        wdata_i = $urandom;
        whilo_i = 1'($urandom);
        hi_i    = $urandom;
        lo_i    = $urandom;
    endtask

    task automatic set_pass();
        e_wd = wd_i; e_wreg = wreg_i; e_wdata = wdata_i; e_whilo = whilo_i;
        e_hi = hi_i; e_lo = lo_i;
        e_stall = 1'b0; e_stb = 1'b0; e_mis = 1'b0;
        chk_wdata = 1'b1; chk_bus = 1'b0; chk_bdata = 1'b0;
    endtask

    task automatic set_zero();
        e_wd = '0; e_wreg = 1'b0; e_wdata = '0; e_whilo = 1'b0; e_hi = '0; e_lo = '0;
        e_stall = 1'b0; e_stb = 1'b0; e_mis = 1'b0;
        e_addr = '0; e_sel = '0; e_we = 1'b0; e_bdata = '0;
        chk_wdata = 1'b1; chk_bus = 1'b1; chk_bdata = 1'b1;
    endtask

    task automatic tick();
        chk_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // flush_at: -1 none, 0 in the issue cycle, c>0 in busy cycle c. rst_at likewise (c>0).
    task automatic run_instr(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                             input int n, input int flush_at, input int rst_at, input logic [31:0] rdata);
        int   sz;
        logic flushed;
        sz = m_size(op);
        stall_seen = 0; writes_seen = 0; stb_seen = 0;
        rand_inputs(op);
        mem_addr_i = addr; reg2_i = reg2;
        flush_i = 1'b0; bus_ack_i = 1'b0; bus_data_i = $urandom;
        set_pass();
        if (flush_at == 0) begin
            flush_i = 1'b1;
            if (sz != 0) begin e_wreg = 1'b0; chk_wdata = 1'b0; end
            model_llbit = 1'b0;
            tick();
            flush_i = 1'b0;
            return;
        end
        if (sz == 0) begin tick(); return; end
        if (addr % sz != 0) begin
            e_mis = 1'b1; e_wreg = 1'b0; chk_wdata = 1'b0;
            tick();
            return;
        end
        if (op == OP_SC && !model_llbit) begin
            e_wdata = 32'd0;
            tick();
            return;
        end
        e_stall = 1'b1; e_wreg = 1'b0; chk_wdata = 1'b0;
        tick();
        flushed = 1'b0;
        for (int c = 1; c <= n; c++) begin
            if (rst_at == c) begin
                rst = 1'b1; set_zero();
                tick();
                rst = 1'b0; model_llbit = 1'b0;
                rand_inputs(OP_NOP); set_pass();
                bus_ack_i = 1'b1; bus_data_i = $urandom;
                tick();
                bus_ack_i = 1'b0;
                return;
            end
            if (flushed) begin
                rand_inputs(OP_NOP); set_pass();
            end else begin
                e_wreg = 1'b0; chk_wdata = 1'b0;
            end
            flush_i = (flush_at == c);
            if (flush_at == c) flushed = 1'b1;
            e_stall = !flushed;
            e_stb = 1'b1; chk_bus = 1'b1;
            e_addr = {addr[31:2], 2'b00}; e_sel = m_sel(sz, addr[1:0]);
            e_we = m_store(op); chk_bdata = m_store(op); e_bdata = m_wbus(sz, reg2);
            bus_ack_i  = (c == n);
            bus_data_i = (c == n) ? rdata : $urandom;
            tick();
            flush_i = 1'b0;
        end
        bus_ack_i = 1'b0; bus_data_i = $urandom;
        if (flushed) return;
        set_pass();
        if (m_store(op)) begin
            if (op == OP_SC) begin
                e_wdata = 32'd1; model_llbit = 1'b0;
            end else begin
                e_wreg = 1'b0; chk_wdata = 1'b0;
            end
        end else begin
            e_wdata = m_load(op, addr[1:0], rdata);
            if (op == OP_LL) model_llbit = 1'b1;
        end
        tick();
    endtask

    initial begin
        logic [7:0] ops [12];
        logic [7:0] op;
        logic [31:0] addr;
        int sz, n, fa, ra, r;
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL, OP_SB, OP_SH, OP_SW, OP_SC, OP_NOP, 8'h25};
        wreg_force = 1'b0;
        model_llbit = 1'b0;
        stall_seen = 0; writes_seen = 0; stb_seen = 0;

        // Reset with a live memory op and ack on the inputs: outputs must be all zero.
        rst = 1'b1; flush_i = 1'b0;
        rand_inputs(OP_LW); mem_addr_i = 32'h100; reg2_i = $urandom;
        bus_ack_i = 1'b1; bus_data_i = $urandom;
        set_zero();
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0; bus_ack_i = 1'b0;

        wreg_force = 1'b1;
        run_instr(OP_LB, 32'h103, 32'h0, 1, -1, -1, 32'h0000_00F0);
        chk("r036_wdata", last_wdata, 32'hFFFF_FFF0);
        chk("r036_sel", {28'd0, last_sel}, 32'h1);
        chk("r036_stall_cycles", stall_seen, 2);
        chk("r036_wreg", {31'd0, last_wreg}, 32'd1);

        run_instr(OP_SH, 32'h202, 32'h1234_ABCD, 2, -1, -1, 32'h0);
        chk("r037_bdata", last_bdata, 32'hABCD_ABCD);
        chk("r037_sel", {28'd0, last_sel}, 32'h3);
        chk("r037_we", {31'd0, last_we}, 32'd1);
        chk("r037_wreg", {31'd0, last_wreg}, 32'd0);

        run_instr(OP_LW, 32'h001, 32'h0, 1, -1, -1, 32'h0);
        chk("r038_mis", {31'd0, last_mis}, 32'd1);
        chk("r038_stb", stb_seen, 0);
        chk("r038_stall", stall_seen, 0);

        run_instr(OP_SC, 32'h40, 32'h55, 1, -1, -1, 32'h0);
        chk("r039_sc_nolink_wdata", last_wdata, 32'd0);
        chk("r039_sc_nolink_writes", writes_seen, 0);
        run_instr(OP_LL, 32'h40, 32'h0, 2, -1, -1, 32'hCAFE_0001);
        chk("r039_ll_wdata", last_wdata, 32'hCAFE_0001);
        run_instr(OP_SC, 32'h40, 32'h77, 1, -1, -1, 32'h0);
        chk("r039_sc_writes", writes_seen, 1);
        chk("r039_sc_wdata", last_wdata, 32'd1);
        run_instr(OP_SC, 32'h40, 32'h77, 1, -1, -1, 32'h0);
        chk("r039_sc_again_wdata", last_wdata, 32'd0);

        run_instr(OP_LL, 32'h80, 32'h0, 1, -1, -1, 32'h1);
        run_instr(OP_LW, 32'h84, 32'h0, 4, 1, -1, 32'h1234_5678);
        chk("r040_stb_held", stb_seen, 4);
        run_instr(OP_SC, 32'h80, 32'h9, 1, -1, -1, 32'h0);
        chk("r040_link_kept", last_wdata, 32'd1);

        run_instr(OP_LL, 32'hC0, 32'h0, 1, -1, -1, 32'h2);
        run_instr(OP_LW, 32'h100, 32'h0, 3, -1, 2, 32'h0);
        chk("r041_stb_cycles", stb_seen, 1);
        run_instr(OP_SC, 32'hC0, 32'h9, 1, -1, -1, 32'h0);
        chk("r041_link_cleared", last_wdata, 32'd0);
        wreg_force = 1'b0;

        for (int i = 0; i < 400; i++) begin
            op = ops[$urandom_range(0, 11)];
            sz = m_size(op);
            addr = $urandom;
            if (sz != 0 && $urandom_range(0, 9) < 8) addr = addr - (addr % sz);
            n = $urandom_range(1, 4);
            r = $urandom_range(0, 19);
            fa = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(1, n)) : -1;
            ra = (fa == -1 && $urandom_range(0, 39) == 0) ? int'($urandom_range(1, n)) : -1;
            run_instr(op, addr, $urandom, n, fa, ra, $urandom);
        end

        chk_en = 1'b0;
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
